// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219-style serial receiver: frame geometry,
// register address map and FSM state encoding.
package max7219_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  // Bit counter values: a full frame, and the saturation point that marks
  // "more than a full frame".
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

  // Register address map (frame bits D11..D8).
  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_DISPTEST  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Map a digit address (1..8) onto its row index (0..7).
  function automatic logic [2:0] digit_row(input logic [3:0] addr);
    logic [3:0] idx;
    idx = addr - 4'd1;
    return idx[2:0];
  endfunction

endpackage

// File: rtl/sc_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, followed by a
// one-cycle rise/fall detector on the synchronized level.
module sc_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  // Fewer than two stages is not a synchronizer; clamp to two.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic         prev_q;

  // Synchronizer chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {N{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign sync_o = sync_q[N-1];
  assign rise_o = sync_q[N-1] & ~prev_q;
  assign fall_o = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/sc_max7219_rx.sv
// MAX7219-compatible serial receiver: captures 16-bit SPI frames framed by
// NCS, validates the bit count and decodes them into the display registers.
module sc_max7219_rx
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int ROW_DATAWIDTH = 8
) (
  input  logic                     SC_MAX7219RX_CLOCK_50,
  input  logic                     SC_MAX7219RX_RESET_InLow,
  input  logic                     SC_MAX7219RX_din_In,
  input  logic                     SC_MAX7219RX_ncs_In,
  input  logic                     SC_MAX7219RX_sclk_In,
  input  logic [2:0]               SC_MAX7219RX_rdaddr_InBUS,
  output logic [ROW_DATAWIDTH-1:0] SC_MAX7219RX_rddata_OutBUS,
  output logic                     SC_MAX7219RX_framevalid_Out,
  output logic [3:0]               SC_MAX7219RX_frameaddr_OutBUS,
  output logic [7:0]               SC_MAX7219RX_framedata_OutBUS,
  output logic                     SC_MAX7219RX_frameerr_Out,
  output logic [3:0]               SC_MAX7219RX_intensity_OutBUS,
  output logic [2:0]               SC_MAX7219RX_scanlimit_OutBUS,
  output logic [7:0]               SC_MAX7219RX_decode_OutBUS,
  output logic                     SC_MAX7219RX_shutdown_Out,
  output logic                     SC_MAX7219RX_disptest_Out
);

  logic clk;
  logic rst_n;
  assign clk   = SC_MAX7219RX_CLOCK_50;
  assign rst_n = SC_MAX7219RX_RESET_InLow;

  // Synchronized serial inputs and their edge events.
  logic din_s, ncs_s, ncs_rise_s, ncs_fall_s, sclk_rise_s;
  logic unused_din_rise_s, unused_din_fall_s, unused_sclk_s, unused_sclk_fall_s;

  sc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
    .clk_i(clk), .rst_ni(rst_n), .d_i(SC_MAX7219RX_din_In),
    .sync_o(din_s), .rise_o(unused_din_rise_s), .fall_o(unused_din_fall_s)
  );

  sc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk_i(clk), .rst_ni(rst_n), .d_i(SC_MAX7219RX_ncs_In),
    .sync_o(ncs_s), .rise_o(ncs_rise_s), .fall_o(ncs_fall_s)
  );

  sc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk), .rst_ni(rst_n), .d_i(SC_MAX7219RX_sclk_In),
    .sync_o(unused_sclk_s), .rise_o(sclk_rise_s), .fall_o(unused_sclk_fall_s)
  );

  // A frame may only start once NCS has been seen high through a fully
  // refilled synchronizer. This stops a frame that straddles reset release
  // (NCS still low) from being picked up half-way and reported as an error.
  logic [SYNC_STAGES:0] warm_q;
  logic                 armed_q;

  // Track synchronizer refill after reset and arm on a genuine NCS-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      if (warm_q[SYNC_STAGES] && ncs_s) begin
        armed_q <= 1'b1;
      end else begin
        armed_q <= armed_q;
      end
    end
  end

  // Frame capture FSM.
  state_e                   state_q, state_d;
  logic [FRAME_BITS-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     commit_ok_s, commit_err_s;

  // State, shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: start on NCS fall, shift on SCLK rise, judge on NCS rise.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    commit_ok_s  = 1'b0;
    commit_err_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall_s && armed_q) begin
          state_d = ST_SHIFT;
          sr_d    = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise_s) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise_s && !ncs_s) begin
          sr_d = {sr_q[FRAME_BITS-2:0], din_s};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 5'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (cnt_q == CNT_FULL) begin
          commit_ok_s = 1'b1;
        end else if (cnt_q != 5'd0) begin
          commit_err_s = 1'b1;
        end else begin
          commit_ok_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame fields; D15..D12 carry no meaning.
  logic [3:0] addr_s;
  logic [7:0] data_s;
  logic [3:0] unused_hi_s;
  assign addr_s      = sr_q[11:8];
  assign data_s      = sr_q[7:0];
  assign unused_hi_s = sr_q[15:12];

  logic [ROW_DATAWIDTH-1:0] row_q [8];
  logic                     valid_q, err_q;
  logic [3:0]               faddr_q, intensity_q;
  logic [7:0]               fdata_q, decode_q;
  logic [2:0]               scanlimit_q;
  logic                     shutdown_q, disptest_q;

  // Result pulses and register file update on an accepted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      faddr_q     <= 4'h0;
      fdata_q     <= 8'h00;
      intensity_q <= 4'h0;
      scanlimit_q <= 3'd0;
      decode_q    <= 8'h00;
      shutdown_q  <= 1'b1;
      disptest_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        row_q[i] <= '0;
      end
    end else begin
      valid_q <= commit_ok_s;
      err_q   <= commit_err_s;
      if (commit_ok_s) begin
        faddr_q <= addr_s;
        fdata_q <= data_s;
        case (addr_s)
          ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
          ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
            row_q[digit_row(addr_s)] <= ROW_DATAWIDTH'(data_s);
          ADDR_DECODE:    decode_q    <= data_s;
          ADDR_INTENSITY: intensity_q <= data_s[3:0];
          ADDR_SCANLIMIT: scanlimit_q <= data_s[2:0];
          ADDR_SHUTDOWN:  shutdown_q  <= ~data_s[0];
          ADDR_DISPTEST:  disptest_q  <= data_s[0];
          default:        decode_q    <= decode_q;
        endcase
      end
    end
  end

  assign SC_MAX7219RX_rddata_OutBUS    = row_q[SC_MAX7219RX_rdaddr_InBUS];
  assign SC_MAX7219RX_framevalid_Out   = valid_q;
  assign SC_MAX7219RX_frameerr_Out     = err_q;
  assign SC_MAX7219RX_frameaddr_OutBUS = faddr_q;
  assign SC_MAX7219RX_framedata_OutBUS = fdata_q;
  assign SC_MAX7219RX_intensity_OutBUS = intensity_q;
  assign SC_MAX7219RX_scanlimit_OutBUS = scanlimit_q;
  assign SC_MAX7219RX_decode_OutBUS    = decode_q;
  assign SC_MAX7219RX_shutdown_Out     = shutdown_q;
  assign SC_MAX7219RX_disptest_Out     = disptest_q;

endmodule

// File: tb/tb_sc_max7219_rx.sv
// Self-checking bench for sc_max7219_rx: directed frames plus random frames,
// compared every cycle against a frame-level behavioural model.
module tb_sc_max7219_rx;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0, ncs = 1'b1, sclk = 1'b0;
  logic [2:0] rdaddr = 3'd0;
  logic [7:0] rddata, fdata, decode;
  logic       fvalid, ferr, shutdown, disptest;
  logic [3:0] faddr, intensity;
  logic [2:0] scanlimit;

  sc_max7219_rx #(.SYNC_STAGES(S), .ROW_DATAWIDTH(8)) dut (
    .SC_MAX7219RX_CLOCK_50(clk),
    .SC_MAX7219RX_RESET_InLow(rst_n),
    .SC_MAX7219RX_din_In(din),
    .SC_MAX7219RX_ncs_In(ncs),
    .SC_MAX7219RX_sclk_In(sclk),
    .SC_MAX7219RX_rdaddr_InBUS(rdaddr),
    .SC_MAX7219RX_rddata_OutBUS(rddata),
    .SC_MAX7219RX_framevalid_Out(fvalid),
    .SC_MAX7219RX_frameaddr_OutBUS(faddr),
    .SC_MAX7219RX_framedata_OutBUS(fdata),
    .SC_MAX7219RX_frameerr_Out(ferr),
    .SC_MAX7219RX_intensity_OutBUS(intensity),
    .SC_MAX7219RX_scanlimit_OutBUS(scanlimit),
    .SC_MAX7219RX_decode_OutBUS(decode),
    .SC_MAX7219RX_shutdown_Out(shutdown),
    .SC_MAX7219RX_disptest_Out(disptest)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_row [8];
  logic [3:0] m_faddr, m_int;
  logic [7:0] m_fdata, m_dec;
  logic [2:0] m_scan;
  logic       m_shut, m_test;
  int         m_valid_cnt = 0, m_err_cnt = 0;
  int         dut_valid_cnt = 0, dut_err_cnt = 0;

  // Pending frame result, posted by the stimulus when NCS goes high.
  int          pend_cnt = 0;
  int          pend_bits = 0;
  logic [15:0] pend_val = 16'h0;
  bit          chk_en = 1'b0;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_row[i] = 8'h00;
    m_faddr = 4'h0; m_fdata = 8'h00; m_int = 4'h0; m_scan = 3'd0;
    m_dec = 8'h00; m_shut = 1'b1; m_test = 1'b0;
  endfunction

  // Returns 1 for an accepted frame, 2 for a rejected one, 0 for nothing.
  function automatic int model_apply(input int nbits, input logic [15:0] v);
    int a;
    if (nbits == 16) begin
      a = int'(v[11:8]);
      m_faddr = v[11:8];
      m_fdata = v[7:0];
      if (a >= 1 && a <= 8) m_row[a-1] = v[7:0];
      else if (a == 9)  m_dec  = v[7:0];
      else if (a == 10) m_int  = v[3:0];
      else if (a == 11) m_scan = v[2:0];
      else if (a == 12) m_shut = ~v[0];
      else if (a == 15) m_test = v[0];
      return 1;
    end
    return (nbits == 0) ? 0 : 2;
  endfunction

  // Per-cycle compare process.
  initial begin
    int r;
    logic ev, ee;
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      ev = 1'b0; ee = 1'b0;
      if (!rst_n) begin
        model_reset();
        pend_cnt = 0;
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          r = model_apply(pend_bits, pend_val);
          ev = (r == 1);
          ee = (r == 2);
          if (ev) m_valid_cnt++;
          if (ee) m_err_cnt++;
        end
      end
      if (fvalid === 1'b1) dut_valid_cnt++;
      if (ferr === 1'b1) dut_err_cnt++;
      if (chk_en) begin
        chk("framevalid", {31'd0, fvalid}, {31'd0, ev});
        chk("frameerr",   {31'd0, ferr},   {31'd0, ee});
        chk("frameaddr",  {28'd0, faddr},  {28'd0, m_faddr});
        chk("framedata",  {24'd0, fdata},  {24'd0, m_fdata});
        chk("intensity",  {28'd0, intensity}, {28'd0, m_int});
        chk("scanlimit",  {29'd0, scanlimit}, {29'd0, m_scan});
        chk("decode",     {24'd0, decode}, {24'd0, m_dec});
        chk("shutdown",   {31'd0, shutdown}, {31'd0, m_shut});
        chk("disptest",   {31'd0, disptest}, {31'd0, m_test});
        chk("rddata",     {24'd0, rddata}, {24'd0, m_row[rdaddr]});
      end
    end
  end

  // Read-address driver: random when enabled, otherwise a fixed row.
  bit         rd_rand = 1'b0;
  logic [2:0] rd_fixed = 3'd0;
  initial begin
    forever begin
      @(negedge clk);
      rdaddr = rd_rand ? 3'($urandom_range(0, 7)) : rd_fixed;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic b);
    din = b;
    cyc(4);
    sclk = 1'b1;
    cyc(4);
    sclk = 1'b0;
  endtask

  task automatic close_frame(input int nbits, input logic [15:0] v);
    cyc(4);
    ncs = 1'b1;
    pend_bits = nbits;
    pend_val  = v;
    pend_cnt  = S + 2;
    cyc(12);
  endtask

  task automatic send_frame(input logic [31:0] v, input int nbits);
    ncs = 1'b0;
    cyc(4);
    for (int i = nbits - 1; i >= 0; i--) sclk_bit(v[i]);
    close_frame(nbits, v[15:0]);
  endtask

  task automatic noise_ncs_high(input int n);
    for (int i = 0; i < n; i++) begin
      din = 1'($urandom_range(0, 1));
      cyc(3);
      sclk = 1'b1;
      cyc(3);
      sclk = 1'b0;
    end
    cyc(6);
  endtask

  int          v0, e0;
  logic [15:0] f;

  initial begin
    cyc(5);
    rst_n = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    cyc(10);
    // reset-state literals
    chk("rst_shutdown", {31'd0, shutdown}, 32'd1);
    chk("rst_intensity", {28'd0, intensity}, 32'd0);
    chk("rst_rddata", {24'd0, rddata}, 32'd0);

    // frame 0x0381 -> row[2] = 0x81
    rd_fixed = 3'd2;
    v0 = dut_valid_cnt;
    send_frame(32'h0381, 16);
    chk("lit_row2", {24'd0, rddata}, 32'h81);
    chk("lit_model_row2", {24'd0, m_row[2]}, 32'h81);
    chk("lit_valid_0381", dut_valid_cnt - v0, 32'd1);
    chk("lit_faddr_0381", {28'd0, faddr}, 32'h3);

    // control registers
    send_frame(32'h0A0F, 16);
    send_frame(32'h0B07, 16);
    send_frame(32'h0C01, 16);
    chk("lit_intensity", {28'd0, intensity}, 32'hF);
    chk("lit_scanlimit", {29'd0, scanlimit}, 32'd7);
    chk("lit_shutdown", {31'd0, shutdown}, 32'd0);
    chk("lit_model_int", {28'd0, m_int}, 32'hF);

    // row[0] = 0xC3, then 15-bit and 17-bit frames to addr 1
    rd_fixed = 3'd0;
    send_frame(32'h01C3, 16);
    v0 = dut_valid_cnt; e0 = dut_err_cnt;
    send_frame(32'h01AA, 15);
    chk("lit_err15", dut_err_cnt - e0, 32'd1);
    send_frame({15'd0, 17'h001AA}, 17);
    chk("lit_err_total", dut_err_cnt - e0, 32'd2);
    chk("lit_no_valid_bad", dut_valid_cnt - v0, 32'd0);
    chk("lit_row0_kept", {24'd0, rddata}, 32'hC3);

    // NCS low/high without SCLK
    v0 = dut_valid_cnt; e0 = dut_err_cnt;
    send_frame(32'h0, 0);
    chk("lit_empty_pulses", (dut_valid_cnt - v0) + (dut_err_cnt - e0), 32'd0);
    chk("lit_empty_int", {28'd0, intensity}, 32'hF);

    // reset after bit 8 of 0x0155, master keeps clocking the rest
    f = 16'h0155;
    v0 = dut_valid_cnt; e0 = dut_err_cnt;
    ncs = 1'b0;
    cyc(4);
    for (int i = 15; i >= 8; i--) sclk_bit(f[i]);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    for (int i = 7; i >= 0; i--) sclk_bit(f[i]);
    cyc(4);
    ncs = 1'b1;
    cyc(12);
    chk("lit_abort_pulses", (dut_valid_cnt - v0) + (dut_err_cnt - e0), 32'd0);
    chk("lit_abort_row0", {24'd0, rddata}, 32'h00);
    send_frame(32'h0155, 16);
    chk("lit_after_rst_row0", {24'd0, rddata}, 32'h55);
    chk("lit_after_rst_valid", dut_valid_cnt - v0, 32'd1);

    // SCLK toggling while NCS high, then 0x08FF
    rd_fixed = 3'd7;
    v0 = dut_valid_cnt; e0 = dut_err_cnt;
    noise_ncs_high(20);
    send_frame(32'h08FF, 16);
    chk("lit_row7", {24'd0, rddata}, 32'hFF);
    chk("lit_one_valid", dut_valid_cnt - v0, 32'd1);
    chk("lit_noise_err", dut_err_cnt - e0, 32'd0);

    // random frames
    rd_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int sel, nb;
      sel = $urandom_range(0, 9);
      if (sel < 7)       nb = 16;
      else if (sel == 7) nb = $urandom_range(1, 15);
      else if (sel == 8) nb = 17;
      else               nb = 0;
      if ($urandom_range(0, 3) == 0) noise_ncs_high(3);
      send_frame($urandom, nb);
    end
    cyc(10);
    chk("total_valid", dut_valid_cnt, m_valid_cnt);
    chk("total_err", dut_err_cnt, m_err_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_max7219_rx.md
SC_MAX7219_RX -- requirements
Module: sc_max7219_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on each serial input (minimum 2).
REQ-002 SHALL have parameter ROW_DATAWIDTH, default 8, meaning the width of each display row.
REQ-003 SHALL have port SC_MAX7219RX_CLOCK_50  in  1  system clock; the block has one clock.
REQ-004 SHALL have port SC_MAX7219RX_RESET_InLow  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port SC_MAX7219RX_din_In  in  1  serial data, sampled on the SCLK rising edge.
REQ-006 SHALL have port SC_MAX7219RX_ncs_In  in  1  chip select, active-low.
REQ-007 SHALL have port SC_MAX7219RX_sclk_In  in  1  serial clock, asynchronous to CLOCK_50.
REQ-008 SHALL have port SC_MAX7219RX_rdaddr_InBUS  in  3  row select for readback.
REQ-009 SHALL have port SC_MAX7219RX_rddata_OutBUS  out  8  selected row contents.
REQ-010 SHALL have port SC_MAX7219RX_framevalid_Out  out  1  one-cycle pulse on each accepted frame.
REQ-011 SHALL have port SC_MAX7219RX_frameaddr_OutBUS  out  4  address nibble (D11..D8) of the last accepted frame.
REQ-012 SHALL have port SC_MAX7219RX_framedata_OutBUS  out  8  data byte (D7..D0) of the last accepted frame.
REQ-013 SHALL have port SC_MAX7219RX_frameerr_Out  out  1  one-cycle pulse on each rejected frame.
REQ-014 SHALL have port SC_MAX7219RX_intensity_OutBUS  out  4  intensity register.
REQ-015 SHALL have port SC_MAX7219RX_scanlimit_OutBUS  out  3  scan-limit register.
REQ-016 SHALL have port SC_MAX7219RX_decode_OutBUS  out  8  decode-mode register.
REQ-017 SHALL have port SC_MAX7219RX_shutdown_Out  out  1  high while the device is in shutdown.
REQ-018 SHALL have port SC_MAX7219RX_disptest_Out  out  1  display-test register bit.

Function
REQ-019 SHALL pass din, ncs and sclk through SYNC_STAGES flip-flops each before any use; SCLK is at most CLOCK_50/4.
REQ-020 SHALL detect SCLK rise, NCS fall and NCS rise as one-cycle events on the synchronized signals.
REQ-021 SHALL implement an FSM with states IDLE, SHIFT and COMMIT.
REQ-022 SHALL go IDLE->SHIFT on NCS fall, clearing the 16-bit shift register and the 5-bit bit counter.
REQ-023 SHALL, in SHIFT, shift din MSB-first on each SCLK rise, incrementing the counter saturated at 17.
REQ-024 SHALL ignore SCLK edges whenever NCS is high.
REQ-025 SHALL go SHIFT->COMMIT on NCS rise, then COMMIT->IDLE unconditionally on the next cycle.
REQ-026 SHALL, in COMMIT with count==16, pulse framevalid, update frameaddr/framedata, and write the decoded register.
REQ-027 SHALL, in COMMIT with count in 1..15 or 17, pulse frameerr and leave all registers unchanged.
REQ-028 SHALL, in COMMIT with count==0, produce no pulse and make no change.
REQ-029 SHALL make framevalid or frameerr assert SYNC_STAGES+2 cycles after the raw NCS rise.
REQ-030 SHALL ignore D15..D12 (don't care).
REQ-031 SHALL decode addresses as follows: 0x0 no-op; 0x1..0x8 write row[addr-1]; 0x9 decode; 0xA intensity=D3..D0; 0xB scanlimit=D2..D0; 0xC shutdown=~D0; 0xF disptest=D0; all others no-op.
REQ-032 SHALL still pulse framevalid for no-op addresses.
REQ-033 SHALL drive rddata combinationally as row[rdaddr]; a read of the row written in COMMIT returns the old value in that cycle and the new value from the next cycle.

Reset
REQ-034 SHALL, on reset asserted, asynchronously clear to: FSM IDLE, shift register and counter 0, rows 0, frameaddr/framedata 0, intensity 0, scanlimit 0, decode 0, shutdown 1, disptest 0, pulses 0, synchronizers 0 with ncs stages 1.
REQ-035 SHALL discard any partial frame on reset mid-frame, with no pulse emitted after release.

Structure
REQ-036 SHALL place address constants (NOOP, DIGIT0..7, DECODE, INTENSITY, SCANLIMIT, SHUTDOWN, DISPTEST), FRAME_BITS=16 and the FSM state encoding in shared package max7219_pkg.
REQ-037 SHALL implement synchronizer plus edge detect as sub-module sc_sync_edge, instantiated three times.

Verification
REQ-038 SHALL verify: frame 0x0381 -> framevalid pulse, row[2]=0x81, rddata=0x81 with rdaddr=2.
REQ-039 SHALL verify: frames 0x0A0F, 0x0B07, 0x0C01 -> intensity=0xF, scanlimit=7, shutdown=0.
REQ-040 SHALL verify: 15-bit frame, and separately 17-bit frame, to addr 1 -> frameerr pulse, row[0] unchanged, no framevalid.
REQ-041 SHALL verify: NCS low/high with no SCLK -> neither pulse, all registers unchanged.
REQ-042 SHALL verify: reset asserted after bit 8 of frame 0x0155 -> row[0]=0, no pulse, and the next full frame 0x0155 is accepted.
REQ-043 SHALL verify: SCLK toggling while NCS high, then a valid frame 0x08FF -> only row[7]=0xFF, exactly one framevalid.
